// File: rtl/mul_iterative_32bit_pkg.sv
// Shared types for the iterative RV32M multiplier: opcodes, FSM states and default width.
package mul_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN,
        DONE
    } mul_state_e;

endpackage

// File: rtl/mul_iterative_32bit_if.sv
// Issue/result bus between the execute-stage pipeline (master) and the multiplier (slave).
interface mul_iterative_32bit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      mul_opcode;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result_mul;

    modport master (
        output start, mul_opcode, operand1, operand2,
        input  busy, done, result_mul
    );

    modport slave (
        input  start, mul_opcode, operand1, operand2,
        output busy, done, result_mul
    );
endinterface

// File: rtl/mul_iterative_32bit_sign_unit.sv
// Combinational sign handling: operand magnitudes, result sign, and the final 64-bit
// conditional negation applied before the product slice is taken.
module mul_sign_unit #(
    parameter int XLEN = mul_pkg::XLEN
) (
    input  mul_pkg::mul_op_e   op,
    input  logic [XLEN-1:0]    operand1,
    input  logic [XLEN-1:0]    operand2,
    output logic [XLEN-1:0]    mag1,
    output logic [XLEN-1:0]    mag2,
    output logic               neg,
    input  logic               neg_en,
    input  logic [2*XLEN-1:0]  acc_in,
    output logic [2*XLEN-1:0]  acc_out
);
    import mul_pkg::*;

    logic sign1;
    logic sign2;

    // Unsigned operands contribute sign 0; the most negative value negates to itself,
    // which is exactly its unsigned magnitude.
    assign sign1   = (op != MULHU) && operand1[XLEN-1];
    assign sign2   = ((op == MUL) || (op == MULH)) && operand2[XLEN-1];
    assign mag1    = sign1 ? (~operand1 + XLEN'(1)) : operand1;
    assign mag2    = sign2 ? (~operand2 + XLEN'(1)) : operand2;
    assign neg     = sign1 ^ sign2;
    assign acc_out = neg_en ? (~acc_in + (2*XLEN)'(1)) : acc_in;

endmodule

// File: rtl/mul_iterative_32bit.sv
// Shift-add multiplier for MUL/MULH/MULHSU/MULHU, one adder, up to 33 cycles per product.
// Define MUL_EARLY_EXIT_EN to leave CALC as soon as the remaining multiplier bits are zero.
module mul_iterative_32bit #(
    parameter int XLEN  = mul_pkg::XLEN,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mul_iterative_32bit_if.slave bus
);
    import mul_pkg::*;

    mul_state_e         state;
    mul_op_e            op_q;
    logic               neg_q;
    logic [2*XLEN-1:0]  mcand;
    logic [2*XLEN-1:0]  acc;
    logic [XLEN-1:0]    mplier;
    logic [CNT_W-1:0]   count;
    logic               busy_q;
    logic               done_q;
    logic [XLEN-1:0]    result_q;

    logic [XLEN-1:0]    mag1;
    logic [XLEN-1:0]    mag2;
    logic               neg_in;
    logic [2*XLEN-1:0]  acc_signed;
    logic               last_iter;

    mul_sign_unit #(.XLEN(XLEN)) u_sign (
        .op       (mul_op_e'(bus.mul_opcode)),
        .operand1 (bus.operand1),
        .operand2 (bus.operand2),
        .mag1     (mag1),
        .mag2     (mag2),
        .neg      (neg_in),
        .neg_en   (neg_q),
        .acc_in   (acc),
        .acc_out  (acc_signed)
    );

`ifdef MUL_EARLY_EXIT_EN
    assign last_iter = (count == CNT_W'(XLEN-1)) || (mplier[XLEN-1:1] == '0);
`else
    assign last_iter = (count == CNT_W'(XLEN-1));
`endif

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.result_mul = result_q;

    // FSM and datapath share one register block so busy/done/result stay glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= MUL;
            neg_q    <= 1'b0;
            mcand    <= '0;
            acc      <= '0;
            mplier   <= '0;
            count    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= mul_op_e'(bus.mul_opcode);
                        mcand  <= {{XLEN{1'b0}}, mag1};
                        mplier <= mag2;
                        acc    <= '0;
                        count  <= '0;
                        neg_q  <= neg_in;
                        busy_q <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CNT_W'(1);
                    if (last_iter) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    acc      <= acc_signed;
                    result_q <= (op_q == MUL) ? acc_signed[XLEN-1:0] : acc_signed[2*XLEN-1:XLEN];
                    done_q   <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
